// File: rtl/instdecode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instdecode_pkg
//  Purpose  : Shared DLX decode definitions: field positions, opcodes,
//             the ID/EX bundle type and immediate-extension helper.
//  Revision : 1.0 - initial release
// ============================================================================
package instdecode_pkg;

   // Instruction field bit positions
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS1_MSB = 25;
   localparam int RS1_LSB = 21;
   localparam int RS2_MSB = 20;
   localparam int RS2_LSB = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQZ  = 6'h04;
   localparam logic [5:0] OP_BNEZ  = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LHI   = 6'h0F;
   localparam logic [5:0] OP_JR    = 6'h12;
   localparam logic [5:0] OP_JALR  = 6'h13;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] DLX_NOP      = 32'h0000_0000;
   localparam logic [4:0]  DLX_LINK_REG = 5'd31;

   // One ID/EX bundle
   typedef struct packed {
      logic        valid;
      logic [31:0] ir;
      logic [31:0] npc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jump;
      logic        is_link;
   } idex_t;

   // Bubble: NOP word, no flags, every other field zero
   function automatic idex_t dlx_bubble();
      idex_t b;
      b    = '0;
      b.ir = DLX_NOP;
      return b;
   endfunction

   // Immediate extension selected by opcode
   function automatic logic [31:0] dlx_imm(input logic [31:0] ir);
      logic [5:0]  op;
      logic [31:0] imm;
      op  = ir[OPC_MSB:OPC_LSB];
      imm = {{16{ir[15]}}, ir[15:0]};
      if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
         imm = {16'h0000, ir[15:0]};
      else if (op == OP_LHI)
         imm = {ir[15:0], 16'h0000};
      else if (op == OP_J || op == OP_JAL)
         imm = {{6{ir[25]}}, ir[25:0]};
      return imm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_regfile
//  Purpose  : 32x32 general register file, two combinational read ports,
//             one write port, write-through bypass, r0 hard-wired to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module dlx_regfile #(
   parameter int RF_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data
);

   logic [31:0] regs [RF_DEPTH];

   // Register array: reset clears all, otherwise writeback (never r0)
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RF_DEPTH; i++)
            regs[i] <= '0;
      end else if (wb_en && wb_addr != 5'd0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Read port 1: r0 is zero, same-cycle writeback wins over array
   always_comb begin
      rs1_data = '0;
      if (rs1_addr == 5'd0)
         rs1_data = '0;
      else if (wb_en && wb_addr == rs1_addr)
         rs1_data = wb_data;
      else
         rs1_data = regs[rs1_addr];
   end

   // Read port 2: same policy as port 1
   always_comb begin
      rs2_data = '0;
      if (rs2_addr == 5'd0)
         rs2_data = '0;
      else if (wb_en && wb_addr == rs2_addr)
         rs2_data = wb_data;
      else
         rs2_data = regs[rs2_addr];
   end

endmodule
`default_nettype wire

// File: rtl/instdecode.sv
`default_nettype none
// ============================================================================
//  Module   : instdecode
//  Purpose  : DLX decode stage: one-entry holding register, register read,
//             immediate extension, load-use hazard stall, ID/EX register.
//  Revision : 1.0 - initial release
// ============================================================================
module instdecode
   import instdecode_pkg::*;
#(
   parameter int RF_DEPTH = 32
) (
   input  logic        clock2,
   input  logic        reset2,
   input  logic [31:0] ir_in2,
   input  logic [31:0] npc_in2,
   input  logic        ir_valid2,
   input  logic        flush2,
   input  logic        wb_en2,
   input  logic [4:0]  wb_addr2,
   input  logic [31:0] wb_data2,
   output logic        stall2,
   output logic        valid_out2,
   output logic [31:0] irout2,
   output logic [31:0] npcout2,
   output logic [31:0] aout2,
   output logic [31:0] bout2,
   output logic [31:0] immout2,
   output logic [4:0]  rdout2,
   output logic        is_load2,
   output logic        is_store2,
   output logic        is_branch2,
   output logic        is_jump2,
   output logic        is_link2
);

   logic [31:0] pend_ir;
   logic [31:0] pend_pc;
   logic        pend_valid;
   idex_t       idex;
   idex_t       dec;
   logic [5:0]  opcode;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        uses_rs1;
   logic        uses_rs2;

   assign opcode = pend_ir[OPC_MSB:OPC_LSB];
   assign rs1    = pend_ir[RS1_MSB:RS1_LSB];
   assign rs2    = pend_ir[RS2_MSB:RS2_LSB];

   dlx_regfile #(
      .RF_DEPTH (RF_DEPTH)
   ) u_regfile (
      .clk      (clock2),
      .reset    (reset2),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_data (rs1_val),
      .rs2_data (rs2_val),
      .wb_en    (wb_en2),
      .wb_addr  (wb_addr2),
      .wb_data  (wb_data2)
   );

   // Decode the held instruction into a candidate ID/EX bundle
   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.ir        = pend_ir;
      dec.npc       = pend_pc;
      dec.a         = rs1_val;
      dec.b         = rs2_val;
      dec.imm       = dlx_imm(pend_ir);
      dec.is_load   = (opcode >= OP_LB) && (opcode <= OP_LHU);
      dec.is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
      dec.is_branch = (opcode == OP_BEQZ) || (opcode == OP_BNEZ);
      dec.is_jump   = (opcode == OP_J) || (opcode == OP_JAL) ||
                      (opcode == OP_JR) || (opcode == OP_JALR);
      dec.is_link   = (opcode == OP_JAL) || (opcode == OP_JALR);
      if (opcode == OP_RTYPE)
         dec.rd = pend_ir[RD_MSB:RD_LSB];
      else if (dec.is_link)
         dec.rd = DLX_LINK_REG;
      else if (dec.is_store || dec.is_branch || dec.is_jump)
         dec.rd = 5'd0;   // J and JR remain here: jumps without link
      else
         dec.rd = pend_ir[RS2_MSB:RS2_LSB];
      uses_rs1 = !((opcode == OP_J) || (opcode == OP_JAL));
      uses_rs2 = (opcode == OP_RTYPE) || dec.is_store;
   end

   // Load-use hazard: depends only on held instruction and ID/EX state
   assign stall2 = pend_valid && idex.valid && idex.is_load && (idex.rd != 5'd0) &&
                   (((idex.rd == rs1) && uses_rs1) || ((idex.rd == rs2) && uses_rs2));

   // Holding register: flush still captures the redirect target
   always_ff @(posedge clock2) begin
      if (reset2) begin
         pend_valid <= 1'b0;
         pend_ir    <= '0;
         pend_pc    <= '0;
      end else if (flush2) begin
         pend_valid <= ir_valid2;
         if (ir_valid2) begin
            pend_ir <= ir_in2;
            pend_pc <= npc_in2;
         end
      end else if (ir_valid2 && !stall2) begin
         pend_valid <= 1'b1;
         pend_ir    <= ir_in2;
         pend_pc    <= npc_in2;
      end else if (!stall2) begin
         pend_valid <= 1'b0;   // held entry consumed, or already empty
      end
   end

   // ID/EX register: bubble on reset, flush, empty or stall
   always_ff @(posedge clock2) begin
      if (reset2)
         idex <= '0;
      else if (flush2 || !pend_valid || stall2)
         idex <= dlx_bubble();
      else
         idex <= dec;
   end

   assign valid_out2 = idex.valid;
   assign irout2     = idex.ir;
   assign npcout2    = idex.npc;
   assign aout2      = idex.a;
   assign bout2      = idex.b;
   assign immout2    = idex.imm;
   assign rdout2     = idex.rd;
   assign is_load2   = idex.is_load;
   assign is_store2  = idex.is_store;
   assign is_branch2 = idex.is_branch;
   assign is_jump2   = idex.is_jump;
   assign is_link2   = idex.is_link;

endmodule
`default_nettype wire

// File: tb/tb_instdecode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instdecode
//  Purpose  : Self-checking bench for instdecode: directed scenarios plus
//             random instruction streams against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instdecode;

   logic        clock2 = 1'b0;
   logic        reset2, ir_valid2, flush2, wb_en2;
   logic [31:0] ir_in2, npc_in2, wb_data2;
   logic [4:0]  wb_addr2;
   logic        stall2, valid_out2, is_load2, is_store2, is_branch2, is_jump2, is_link2;
   logic [31:0] irout2, npcout2, aout2, bout2, immout2;
   logic [4:0]  rdout2;

   always #5 clock2 = ~clock2;

   instdecode #(.RF_DEPTH(32)) dut (
      .clock2(clock2), .reset2(reset2), .ir_in2(ir_in2), .npc_in2(npc_in2),
      .ir_valid2(ir_valid2), .flush2(flush2), .wb_en2(wb_en2), .wb_addr2(wb_addr2),
      .wb_data2(wb_data2), .stall2(stall2), .valid_out2(valid_out2), .irout2(irout2),
      .npcout2(npcout2), .aout2(aout2), .bout2(bout2), .immout2(immout2),
      .rdout2(rdout2), .is_load2(is_load2), .is_store2(is_store2),
      .is_branch2(is_branch2), .is_jump2(is_jump2), .is_link2(is_link2)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] ir, npc, a, b, imm;
      logic [4:0]  rd;
      logic        ld, st, br, jp, lk;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_rf [32];
   logic [31:0] m_pend_ir, m_pend_pc;
   logic        m_pend_v;
   exp_t        m_out;
   logic [5:0]  ops [15];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      return {6'h00, s1, s2, d, 11'h020};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] d, input logic [15:0] imm);
      return {op, s1, d, imm};
   endfunction

   // Architectural read as seen by the decoder: r0 zero, writeback visible
   function automatic logic [31:0] m_read(input logic [4:0] r, input logic wbe,
                                          input logic [4:0] wba, input logic [31:0] wbd);
      if (r == 5'd0) return 32'h0;
      if (wbe && wba == r) return wbd;
      return m_rf[r];
   endfunction

   // What the instruction set says each word means
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b);
      exp_t       e;
      logic [5:0] op;
      op      = w[31:26];
      e       = '0;
      e.valid = 1'b1;
      e.ir    = w;
      e.npc   = pc;
      e.a     = a;
      e.b     = b;
      case (op)
         6'h0C, 6'h0D, 6'h0E: e.imm = {16'h0, w[15:0]};
         6'h0F:               e.imm = {w[15:0], 16'h0};
         6'h02, 6'h03:        e.imm = {{6{w[25]}}, w[25:0]};
         default:             e.imm = {{16{w[15]}}, w[15:0]};
      endcase
      e.ld = (op >= 6'h20 && op <= 6'h25);
      e.st = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
      e.br = (op == 6'h04 || op == 6'h05);
      e.jp = (op == 6'h02 || op == 6'h03 || op == 6'h12 || op == 6'h13);
      e.lk = (op == 6'h03 || op == 6'h13);
      case (op)
         6'h00:                             e.rd = w[15:11];
         6'h03, 6'h13:                      e.rd = 5'd31;
         6'h28, 6'h29, 6'h2B, 6'h04, 6'h05,
         6'h02, 6'h12:                      e.rd = 5'd0;
         default:                           e.rd = w[20:16];
      endcase
      return e;
   endfunction

   // Load in ID/EX whose target the waiting instruction reads
   function automatic logic m_hazard();
      logic [5:0] op;
      logic       r1, r2;
      op = m_pend_ir[31:26];
      r1 = !(op == 6'h02 || op == 6'h03);
      r2 = (op == 6'h00) || (op == 6'h28 || op == 6'h29 || op == 6'h2B);
      return m_pend_v && m_out.valid && m_out.ld && m_out.rd != 5'd0 &&
             ((m_out.rd == m_pend_ir[25:21] && r1) || (m_out.rd == m_pend_ir[20:16] && r2));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_pend_v  = 1'b0;
      m_pend_ir = 32'h0;
      m_pend_pc = 32'h0;
      m_out     = '0;
   endtask

   task automatic check_outs();
      chk("valid", {31'b0, valid_out2}, {31'b0, m_out.valid});
      chk("ir",    irout2,  m_out.ir);
      chk("npc",   npcout2, m_out.npc);
      chk("a",     aout2,   m_out.a);
      chk("b",     bout2,   m_out.b);
      chk("imm",   immout2, m_out.imm);
      chk("rd",    {27'b0, rdout2}, {27'b0, m_out.rd});
      chk("flags", {27'b0, is_load2, is_store2, is_branch2, is_jump2, is_link2},
                   {27'b0, m_out.ld, m_out.st, m_out.br, m_out.jp, m_out.lk});
   endtask

   // One clock: drive, check stall, advance model, check ID/EX
   task automatic step(input logic rst, input logic [31:0] w, input logic [31:0] pc,
                       input logic irv, input logic fl, input logic wbe,
                       input logic [4:0] wba, input logic [31:0] wbd);
      logic        hz;
      logic [31:0] a, b;
      reset2 = rst; ir_in2 = w; npc_in2 = pc; ir_valid2 = irv; flush2 = fl;
      wb_en2 = wbe; wb_addr2 = wba; wb_data2 = wbd;
      #1;
      hz = m_hazard();
      chk("stall", {31'b0, stall2}, {31'b0, hz});
      if (rst) begin
         model_reset();
      end else begin
         a = m_read(m_pend_ir[25:21], wbe, wba, wbd);
         b = m_read(m_pend_ir[20:16], wbe, wba, wbd);
         if (fl) begin
            m_out    = '0;
            m_pend_v = irv;
            if (irv) begin m_pend_ir = w; m_pend_pc = pc; end
         end else begin
            m_out = (!m_pend_v || hz) ? '0 : ref_decode(m_pend_ir, m_pend_pc, a, b);
            if (irv && !hz) begin
               m_pend_v = 1'b1; m_pend_ir = w; m_pend_pc = pc;
            end else if (!hz) begin
               m_pend_v = 1'b0;
            end
         end
         if (wbe && wba != 5'd0) m_rf[wba] = wbd;
      end
      @(posedge clock2);
      #1;
      check_outs();
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic issue(input logic [31:0] w, input logic [31:0] pc);
      step(1'b0, w, pc, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      logic [31:0] w;
      ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h12,
              6'h13, 6'h04, 6'h05, 6'h23, 6'h20, 6'h2B, 6'h28};

      // Reset held two cycles with a writeback to r5 pending
      reset2 = 1'b1; ir_in2 = 32'h0; npc_in2 = 32'h0; ir_valid2 = 1'b0; flush2 = 1'b0;
      wb_en2 = 1'b1; wb_addr2 = 5'd5; wb_data2 = 32'hCAFE_F00D;
      repeat (2) @(posedge clock2);
      #1;
      model_reset();
      check_outs();
      chk("rst_stall", {31'b0, stall2}, 32'd0);

      // r5 must not have absorbed the writeback during reset
      issue(enc_r(5'd5, 5'd0, 5'd8), 32'h100);
      idle();
      chk("r5_after_rst", aout2, 32'h0);

      // R-type with bypass on the decode edge
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd7);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd9);
      issue(enc_r(5'd1, 5'd2, 5'd3), 32'h104);
      chk("add_latency", {31'b0, valid_out2}, 32'd0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h55);
      chk("add_valid", {31'b0, valid_out2}, 32'd1);
      chk("add_a", aout2, 32'd7);
      chk("add_b", bout2, 32'h55);
      chk("add_rd", {27'b0, rdout2}, 32'd3);

      // Immediate forms
      issue(enc_i(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'h108); idle();
      chk("addi_imm", immout2, 32'hFFFF_FFFF);
      issue(enc_i(6'h0D, 5'd1, 5'd4, 16'h8000), 32'h10C); idle();
      chk("ori_imm", immout2, 32'h0000_8000);
      issue(enc_i(6'h0F, 5'd0, 5'd4, 16'h1234), 32'h110); idle();
      chk("lhi_imm", immout2, 32'h1234_0000);
      w = {6'h03, 26'h3FF_FFFC};
      issue(w, 32'h114); idle();
      chk("jal_imm", immout2, 32'hFFFF_FFFC);
      chk("jal_rd", {27'b0, rdout2}, 32'd31);
      chk("jal_link", {31'b0, is_link2}, 32'd1);

      // Load-use: one stall cycle, bubble, then the consumer
      issue(enc_i(6'h23, 5'd1, 5'd6, 16'h0), 32'h200);
      issue(enc_r(5'd6, 5'd2, 5'd7), 32'h204);
      chk("lu_stall", {31'b0, stall2}, 32'd1);
      issue(enc_r(5'd6, 5'd2, 5'd7), 32'h204);
      chk("lu_bubble", {31'b0, valid_out2}, 32'd0);
      chk("lu_stall_gone", {31'b0, stall2}, 32'd0);
      idle();
      chk("lu_consumer", irout2, enc_r(5'd6, 5'd2, 5'd7));

      // Load followed by an independent instruction
      issue(enc_i(6'h23, 5'd1, 5'd6, 16'h0), 32'h210);
      issue(enc_r(5'd1, 5'd2, 5'd7), 32'h214);
      chk("nolu_stall", {31'b0, stall2}, 32'd0);
      idle();
      chk("nolu_issue", irout2, enc_r(5'd1, 5'd2, 5'd7));

      // Flush with a target instruction arriving on the same edge
      issue(enc_i(6'h08, 5'd1, 5'd10, 16'h0011), 32'h300);
      step(1'b0, enc_i(6'h0D, 5'd2, 5'd11, 16'hBEEF), 32'h400, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("flush_bubble", {31'b0, valid_out2}, 32'd0);
      idle();
      chk("flush_target", irout2, enc_i(6'h0D, 5'd2, 5'd11, 16'hBEEF));
      chk("flush_target_pc", npcout2, 32'h400);
      idle();
      chk("flush_old_gone", {31'b0, valid_out2}, 32'd0);

      // r0 guard: writeback to r0 neither stored nor bypassed
      issue(enc_r(5'd0, 5'd2, 5'd9), 32'h500);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD);
      chk("r0_bypass", aout2, 32'h0);
      issue(enc_i(6'h23, 5'd1, 5'd0, 16'h0), 32'h504);
      issue(enc_r(5'd0, 5'd0, 5'd9), 32'h508);
      chk("r0_load_stall", {31'b0, stall2}, 32'd0);
      idle(); idle();

      // Reset in the middle of a stall
      issue(enc_i(6'h23, 5'd1, 5'd6, 16'h0), 32'h600);
      issue(enc_r(5'd6, 5'd6, 5'd7), 32'h604);
      step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h77);
      chk("midstall_rst_stall", {31'b0, stall2}, 32'd0);
      chk("midstall_rst_valid", {31'b0, valid_out2}, 32'd0);
      idle();

      // Random instruction streams with small register indices to force hazards
      for (int n = 0; n < 400; n++) begin
         w        = $urandom;
         w[31:26] = ops[$urandom_range(0, 14)];
         w[25:21] = 5'($urandom_range(0, 3));
         w[20:16] = 5'($urandom_range(0, 3));
         w[15:11] = 5'($urandom_range(0, 7));
         step($urandom_range(0, 60) == 0, w, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 5)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
